// File: rtl/hidden_feeder_pkg.sv
// hidden_feeder_pkg: feeder state encoding, NOP instruction and cpu_io field layout.
package hidden_feeder_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RESET, ST_RUN, ST_HALT} state_t;
    localparam logic [5:0] NOP_INSTR = 6'b000000;
    localparam int IO_CLK      = 0;
    localparam int IO_RST      = 1;
    localparam int IO_INSTR_LO = 2;
    localparam int IO_INSTR_HI = 7;
endpackage

// File: rtl/hidden_prog_mem.sv
// hidden_prog_mem: DEPTH x 6 program register file, synchronous write, asynchronous read.
module hidden_prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [5:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [5:0]    rdata
);
    logic [5:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/hidden_prog_feeder.sv
// hidden_prog_feeder: loads a program and feeds it to the HiddenCPU io_in word, generating its clock and reset.
// Optional HIDDEN_FEEDER_SINGLESTEP_EN adds a step input that gates each CPU period.
module hidden_prog_feeder
    import hidden_feeder_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [5:0]               load_data,
    input  logic                     load_last,
    input  logic                     start,
    input  logic                     stop,
`ifdef HIDDEN_FEEDER_SINGLESTEP_EN
    input  logic                     step,
`endif
    input  logic [7:0]               pc_in,
    output logic [7:0]               cpu_io,
    output logic [$clog2(DEPTH):0]   prog_len,
    output logic                     halted,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RST_CYCLES + 1);

    state_t        state, state_n;
    logic          phase, phase_n;
    logic [AW-1:0] wptr, wptr_n;
    logic [AW:0]   prog_len_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [5:0]    instr, instr_n, rdata;
    logic          wr, adv, in_range;

`ifdef HIDDEN_FEEDER_SINGLESTEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    assign in_range = {1'b0, pc_in} < 9'(prog_len);

    hidden_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (wr),
        .waddr ((state == ST_LOAD) ? wptr : '0),
        .wdata (load_data),
        .raddr (pc_in[AW-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            phase    <= 1'b0;
            wptr     <= '0;
            prog_len <= '0;
            cnt      <= '0;
            instr    <= NOP_INSTR;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            wptr     <= wptr_n;
            prog_len <= prog_len_n;
            cnt      <= cnt_n;
            instr    <= instr_n;
        end
    end

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        wptr_n     = wptr;
        prog_len_n = prog_len;
        cnt_n      = cnt;
        instr_n    = instr;
        wr         = 1'b0;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (load_valid) begin
                    wr         = 1'b1;
                    wptr_n     = load_last ? '0 : AW'(1);
                    prog_len_n = load_last ? (AW+1)'(1) : '0;
                    state_n    = load_last ? ST_IDLE : ST_LOAD;
                end else if (start && !stop && prog_len != '0) begin
                    state_n = ST_RESET;
                    phase_n = 1'b0;
                    cnt_n   = '0;
                    instr_n = NOP_INSTR;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    wr     = 1'b1;
                    wptr_n = wptr + AW'(1);
                    if (load_last || wptr == AW'(DEPTH - 1)) begin
                        prog_len_n = {1'b0, wptr} + (AW+1)'(1);
                        wptr_n     = '0;
                        state_n    = ST_IDLE;
                    end
                end
            end
            ST_RESET: begin
                if (stop) begin
                    state_n = ST_HALT;
                    phase_n = 1'b0;
                end else begin
                    phase_n = ~phase;
                    if (phase && cnt == CW'(RST_CYCLES - 1)) state_n = ST_RUN;
                    else if (phase) cnt_n = cnt + CW'(1);
                end
            end
            ST_RUN: begin
                // Instruction and rising cpu_clk are launched together on leaving phase 0
                if (stop) begin
                    state_n = ST_HALT;
                    phase_n = 1'b0;
                end else if (phase) begin
                    phase_n = 1'b0;
                end else if (adv) begin
                    if (in_range) begin
                        instr_n = rdata;
                        phase_n = 1'b1;
                    end else begin
                        state_n = ST_HALT;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_io = '0;
        cpu_io[IO_CLK] = phase && (state == ST_RESET || state == ST_RUN);
        cpu_io[IO_RST] = state inside {ST_IDLE, ST_LOAD, ST_RESET};
        cpu_io[IO_INSTR_HI:IO_INSTR_LO] = (state == ST_RUN) ? instr : NOP_INSTR;
    end

    assign load_ready = state inside {ST_IDLE, ST_LOAD, ST_HALT};
    assign halted     = state == ST_HALT;
    assign busy       = state inside {ST_RESET, ST_RUN};
endmodule

// File: tb/tb_hidden_prog_feeder.sv
// tb_hidden_prog_feeder: scenario tasks with a scoreboard of expected cpu_io words and program lengths.
module tb_hidden_prog_feeder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [5:0] load_data = '0;
    logic       load_last = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] pc_in = '0;
    logic [7:0] cpu_io;
    logic [4:0] prog_len;
    logic       halted;
    logic       busy;
`ifdef HIDDEN_FEEDER_SINGLESTEP_EN
    logic       step = 1'b1;
`endif

    int checks = 0;
    int failures = 0;

    logic [5:0] prog [16];
    int         plen;
    int         pc_q[$];
    logic [7:0] sb[$];
    logic [4:0] len_q[$];

    hidden_prog_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_last  (load_last),
        .start      (start),
        .stop       (stop),
`ifdef HIDDEN_FEEDER_SINGLESTEP_EN
        .step       (step),
`endif
        .pc_in      (pc_in),
        .cpu_io     (cpu_io),
        .prog_len   (prog_len),
        .halted     (halted),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic load_words(input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = last && (i == n - 1);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic boot;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
    endtask

    task automatic run_pcs;
        logic [7:0] e;
        int pc;
        while (pc_q.size() > 0) begin
            pc    = pc_q.pop_front();
            pc_in = 8'(pc);
            sb.push_back(pc < plen ? {prog[pc], 2'b01} : 8'h00);
            tick();
            e = sb.pop_front();
            check8("run_phase1", cpu_io, e);
            if (e == 8'h00) begin
                check8("run_halted", {7'b0, halted}, 8'h01);
                pc_q.delete();
            end else begin
                tick();
                check8("run_phase0_hold", cpu_io, {prog[pc], 2'b00});
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check8("reset_cpu_io", cpu_io, 8'h02);
        check8("reset_flags", {4'b0, load_ready, halted, busy, 1'b0}, 8'h08);
        check8("reset_prog_len", {3'b0, prog_len}, 8'h00);
    endtask

    task automatic test_start_empty;
        start = 1'b1;
        tick();
        start = 1'b0;
        check8("start_empty_busy", {7'b0, busy}, 8'h00);
        check8("start_empty_cpu_io", cpu_io, 8'h02);
    endtask

    task automatic test_load;
        prog[0] = 6'h11;
        prog[1] = 6'h22;
        prog[2] = 6'h3F;
        plen = 3;
        len_q.push_back(5'd3);
        load_words(3, 1'b1);
        check8("load_len", {3'b0, prog_len}, {3'b0, len_q.pop_front()});
        check8("load_idle", {5'b0, load_ready, halted, busy}, 8'h04);
    endtask

    task automatic test_start_reset;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check8("rst_seq", cpu_io, {6'h00, 1'b1, i[0]});
            tick();
        end
        check8("run_entry", cpu_io, 8'h00);
        check8("run_busy", {7'b0, busy}, 8'h01);
    endtask

    task automatic test_run_overrun;
        pc_q = '{0, 1, 2, 0, 3};
        run_pcs();
        check8("overrun_busy", {7'b0, busy}, 8'h00);
    endtask

    task automatic test_restart_and_stop;
        start = 1'b1;
        tick();
        start = 1'b0;
        check8("restart_rst", cpu_io, 8'h02);
        check8("restart_flags", {6'b0, halted, busy}, 8'h01);
        repeat (4) tick();
        pc_in = 8'd1;
        tick();
        check8("stop_pre", cpu_io, {6'h22, 2'b01});
        stop = 1'b1;
        check8("stop_clk_high", {7'b0, cpu_io[0]}, 8'h01);
        tick();
        check8("stop_halt_io", cpu_io, 8'h00);
        check8("stop_halted", {7'b0, halted}, 8'h01);
        stop = 1'b0;
    endtask

    task automatic test_stop_start;
        boot();
        pc_in = 8'd0;
        tick();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        check8("stopstart_halt", {cpu_io[6:0], halted}, 8'h01);
        tick();
        check8("stopstart_stay", {6'b0, halted, busy}, 8'h02);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_full_load;
        for (int i = 0; i < 16; i++) prog[i] = 6'($urandom_range(0, 63));
        len_q.push_back(5'd16);
        load_words(16, 1'b0);
        check8("full_len", {3'b0, prog_len}, {3'b0, len_q.pop_front()});
        check8("full_idle", {5'b0, load_ready, halted, busy}, 8'h04);
        prog[0] = 6'h15;
        prog[1] = 6'h2A;
        load_words(1, 1'b0);
        check8("new_load_len", {3'b0, prog_len}, 8'h00);
        check8("new_load_ready", {7'b0, load_ready}, 8'h01);
        load_valid = 1'b1;
        load_data  = prog[1];
        load_last  = 1'b1;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        plen = 2;
        check8("new_load_done", {3'b0, prog_len}, 8'h02);
        boot();
        pc_q = '{1, 0, 2};
        run_pcs();
    endtask

    task automatic test_async_reset;
        boot();
        pc_in = 8'd0;
        tick();
        #3 rst = 1'b0;
        #1;
        check8("async_cpu_io", cpu_io, 8'h02);
        check8("async_state", {3'b0, prog_len, busy, halted, 1'b0}, 8'h00);
        #2 rst = 1'b1;
        tick();
        check8("async_after", {cpu_io[6:0], busy}, 8'h04);
    endtask

    initial begin
        test_reset();
        test_start_empty();
        test_load();
        test_start_reset();
        test_run_overrun();
        test_restart_and_stop();
        test_stop_start();
        test_full_load();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hidden_prog_feeder.md
# hidden_prog_feeder

Program feeder that sits directly upstream of the HiddenCPU core and drives its 8-bit `io_in` word. It accepts a short program over a valid/ready load port and stores it in a small instruction memory. It then generates the CPU's clock and reset strobes and, each CPU cycle, presents the 6-bit instruction addressed by the CPU's reported program counter. When the program runs off its end, or on request, it halts the CPU cleanly.

## Interface
- `DEPTH`, 16, program memory words; power of two, 2..256.
- `RST_CYCLES`, 2, number of CPU clock periods that CPU reset is held on each start; ≥1.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `load_valid`  in  1  load word offered.
- `load_ready`  out  1  feeder can accept a load word.
- `load_data`  in  6  instruction word, as {opcode[1:0], addrs[3:0]}.
- `load_last`  in  1  qualifies the final word of the program.
- `start`  in  1  level; begin execution of the loaded program.
- `stop`  in  1  level; halt execution.
- `pc_in`  in  8  CPU program counter, fed back from the CPU output.
- `cpu_io`  out  8  drives the CPU `io_in` as {instr[5:0], cpu_rst, cpu_clk}.
- `prog_len`  out  clog2(DEPTH)+1  number of valid program words.
- `halted`  out  1  high in HALT.
- `busy`  out  1  high in RESET or RUN.

## Operation
- States: IDLE, LOAD, RESET, RUN, HALT.
- **IDLE / HALT.** `load_ready`=1. The first accepted word writes to address 0, sets the write pointer to 1, and enters LOAD. `prog_len` is cleared at this point, so a new load discards the old program.
- **LOAD.** `load_ready`=1. Each accepted word is written to `mem[wptr]` and `wptr` increments. On acceptance with `load_last`=1, or when `wptr` reaches DEPTH-1, `prog_len` is set to `wptr+1` and the state returns to IDLE. No overflow is possible. `start` and `stop` are ignored in this state.
- **Start (IDLE or HALT).** `start`=1 with `prog_len`≠0 enters RESET. `start` with `prog_len`=0 is ignored.
- **RESET.**
  - `cpu_rst`=1 and instr=NOP.
  - `cpu_clk` alternates 0,1 for RST_CYCLES CPU periods.
  - Then enters RUN at phase 0.
- **RUN.** Two-phase CPU period.
  - Phase 0: `cpu_clk`=0. The instr register is loaded from `mem[pc_in[clog2(DEPTH)-1:0]]` if `pc_in` < `prog_len`. Otherwise the feeder enters HALT.
  - Phase 1: `cpu_clk`=1. The instr register is held, so the instruction is stable across the CPU's rising edge.
  - `pc_in` is sampled only in phase 0.
- **Halt conditions.**
  - `stop`=1 in RUN or RESET: the feeder finishes the current phase 1 (a high pulse is never truncated), then enters HALT.
  - If `stop` and `start` are both high, `stop` wins.
- **HALT.** `cpu_io` = {NOP, 0, 0} and `halted`=1. `start` restarts the program (via RESET); a load begins a new program.
- Program memory is not reset. `prog_len`=0 guards it.

## Timing
- Reset values: state=IDLE, `cpu_io`=8'h02 (instr NOP, `cpu_rst`=1, `cpu_clk`=0), `load_ready`=1, `prog_len`=0, `halted`=0, `busy`=0, `wptr`=0, phase=0.
- Load throughput is one word per clk. The word is written on the accepting edge.
- `start` sampled at edge N gives RESET from N+1: `cpu_rst`=1, `cpu_clk` 0 at N+1 and 1 at N+2, repeating.
- RUN phase 0 begins at edge N+1+2·RST_CYCLES.
- CPU clock period is 2 clk. The instruction changes only when entering phase 1.
- HALT on overrun is entered on the edge following the phase-0 sample.

## Configuration
- `HIDDEN_FEEDER_SINGLESTEP_EN`
  - Defined: adds input `step` (1 bit). RUN waits in phase 0 until `step`=1, sampling `pc_in` on that edge; each `step` pulse produces exactly one CPU period. `stop` is still honoured while waiting.
  - Undefined: no `step` port; RUN is free-running.

## Structure
- Package `hidden_feeder_pkg`:
  - state enum;
  - `NOP_INSTR`=6'b000000;
  - `cpu_io` bit positions (CLK=0, RST=1, INSTR=7:2).
- Sub-module `hidden_prog_mem`: DEPTH×6 register file with synchronous write and asynchronous read.

## Test plan
- Assert `rst` low mid-RUN → `cpu_io`=8'h02, IDLE, `prog_len`=0, `busy`=0, immediately (asynchronous).
- Load 6'h11, 6'h22, 6'h3F, with `load_last` on the third word → `prog_len`=3, IDLE; `start` with `prog_len`=0 beforehand is ignored.
- After that load, `start`=1 with RST_CYCLES=2 → `cpu_io[1]`=1 for 4 clk with `cpu_clk` 0,1,0,1; then `pc_in`=0 gives `cpu_io[7:2]`=6'h11 with `cpu_clk` rising the following clk.
- `pc_in`=3 in phase 0 → HALT next edge, `cpu_io`=8'h00, `halted`=1; `start` → RESET again.
- Load 16 words with no `load_last` → `prog_len`=16, IDLE; a 17th word starts a new load and sets `prog_len`=0.
- `stop`=1 during phase 1 → `cpu_clk` stays 1 for that clk, then HALT with `cpu_clk`=0; `stop`+`start` together in RUN → HALT.
